aq_djpeg_mcu_sched: RTL and testbench

Per-image MCU/block scheduler for the baseline decoder. It starts when the header FSM raises ImageEnable and latches the frame geometry (component count, luma sampling factors, MCU grid size). It then issues 8x8 block decode commands to the Huffman/IDCT path in JPEG interleaved order and tracks the MCU position. It also sequences restart-interval handling and reports image completion.

---
 rtl/aq_djpeg_mcu_sched.sv | 269 ++++++++++++++++++++++++++
 tb/tb_aq_djpeg_mcu_sched.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aq_djpeg_mcu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : aq_djpeg_mcu_sched
//  Purpose  : Per-image MCU/block scheduler for the baseline JPEG decoder.
//             Latches the frame geometry when the header FSM raises
//             ImageEnable. Issues 8x8 block decode commands in interleaved
//             order (Y blocks in raster order, then Cb, then Cr). Tracks the
//             MCU position, sequences restart markers and reports completion.
//  Ports    :
//     clk, rst          clock, asynchronous active-low reset
//     ImageEnable       level from header FSM, scan data available
//     JpegComp          component count (3 = YCbCr, otherwise grayscale)
//     SubSamplingW/H    luma sampling factors (2 = two blocks, else one)
//     McuCols/McuRows   MCU grid size
//     RstInterval       MCUs per restart interval (0 = disabled)
//     BlockValid/Ready  block command handshake
//     BlockComp/Pos/Table  command fields (component, luma {v,h}, table)
//     BlockDone         decoder finished the accepted block
//     McuX/McuY         MCU owning the issued or in-flight block
//     RstReq/RstAck     restart marker consumption handshake
//     DcClear           one-cycle pulse clearing the DC predictors
//     ImageDone         all MCUs decoded (level)
//     Busy              scheduler not idle
//  Revision : 1.0 - initial release
// ============================================================================
module aq_djpeg_mcu_sched #(
   parameter int BLK_W = 12,
   parameter int RST_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ImageEnable,
   input  logic [2:0]       JpegComp,
   input  logic [1:0]       SubSamplingW,
   input  logic [1:0]       SubSamplingH,
   input  logic [BLK_W-1:0] McuCols,
   input  logic [BLK_W-1:0] McuRows,
   input  logic [RST_W-1:0] RstInterval,
   output logic             BlockValid,
   input  logic             BlockReady,
   output logic [1:0]       BlockComp,
   output logic [1:0]       BlockPos,
   output logic             BlockTable,
   input  logic             BlockDone,
   output logic [BLK_W-1:0] McuX,
   output logic [BLK_W-1:0] McuY,
   output logic             RstReq,
   input  logic             RstAck,
   output logic             DcClear,
   output logic             ImageDone,
   output logic             Busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_RSTW  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]       state_q, state_d;
   logic             color_q, color_d;
   logic             hs2_q,   hs2_d;
   logic             vs2_q,   vs2_d;
   logic [BLK_W-1:0] cols_q,  cols_d;
   logic [BLK_W-1:0] rows_q,  rows_d;
   logic [RST_W-1:0] rsti_q,  rsti_d;
   logic [BLK_W-1:0] mcux_q,  mcux_d;
   logic [BLK_W-1:0] mcuy_q,  mcuy_d;
   logic [RST_W-1:0] rcnt_q,  rcnt_d;
   logic [2:0]       blk_q,   blk_d;
   logic             dcclr_q, dcclr_d;

   // Block index decode
   logic [2:0] luma_n;     // Y blocks per MCU: 1, 2 or 4
   logic [2:0] last_blk;   // index of the final block of an MCU
   logic [1:0] blk_comp;
   logic [1:0] blk_pos;
   logic       mcu_last;   // current MCU is the bottom-right one
   logic       col_last;

   always_comb begin
      luma_n = 3'd1;
      if (hs2_q && vs2_q) begin
         luma_n = 3'd4;
      end else if (hs2_q || vs2_q) begin
         luma_n = 3'd2;
      end

      // Colour MCUs carry the luma blocks plus one Cb and one Cr.
      last_blk = color_q ? (luma_n + 3'd1) : 3'd0;

      blk_comp = 2'd0;
      blk_pos  = 2'd0;
      if (color_q) begin
         if (blk_q < luma_n) begin
            // Position is {v,h}. With two columns the index already is
            // {v,h}. With a single column the index walks v only, so h
            // stays zero.
            if (hs2_q) begin
               blk_pos = blk_q[1:0];
            end else if (vs2_q) begin
               blk_pos = {blk_q[0], 1'b0};
            end
         end else begin
            blk_comp = (blk_q == luma_n) ? 2'd1 : 2'd2;
         end
      end
   end

   assign col_last = (mcux_q == (cols_q - BLK_W'(1)));
   assign mcu_last = col_last && (mcuy_q == (rows_q - BLK_W'(1)));

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      hs2_d   = hs2_q;
      vs2_d   = vs2_q;
      cols_d  = cols_q;
      rows_d  = rows_q;
      rsti_d  = rsti_q;
      mcux_d  = mcux_q;
      mcuy_d  = mcuy_q;
      rcnt_d  = rcnt_q;
      blk_d   = blk_q;
      dcclr_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (ImageEnable) begin
               color_d = (JpegComp == 3'd3);
               hs2_d   = (SubSamplingW == 2'd2);
               vs2_d   = (SubSamplingH == 2'd2);
               cols_d  = McuCols;
               rows_d  = McuRows;
               rsti_d  = RstInterval;
               mcux_d  = '0;
               mcuy_d  = '0;
               rcnt_d  = '0;
               blk_d   = '0;
               // An empty grid has nothing to decode.
               if ((McuCols == '0) || (McuRows == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            if (BlockReady) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (BlockDone) begin
               state_d = S_NEXT;
            end
         end

         S_NEXT: begin
            if (blk_q != last_blk) begin
               blk_d   = blk_q + 3'd1;
               state_d = S_ISSUE;
            end else begin
               blk_d = '0;
               if (mcu_last) begin
                  // Position stays on the final MCU. The grid never
                  // advances past McuRows.
                  state_d = S_DONE;
               end else begin
                  if (col_last) begin
                     mcux_d = '0;
                     mcuy_d = mcuy_q + BLK_W'(1);
                  end else begin
                     mcux_d = mcux_q + BLK_W'(1);
                  end
                  if ((rsti_q != '0) && ((rcnt_q + RST_W'(1)) == rsti_q)) begin
                     rcnt_d  = '0;
                     state_d = S_RSTW;
                  end else begin
                     rcnt_d  = rcnt_q + RST_W'(1);
                     state_d = S_ISSUE;
                  end
               end
            end
         end

         S_RSTW: begin
            if (RstAck) begin
               dcclr_d = 1'b1;
               state_d = S_ISSUE;
            end
         end

         S_DONE: begin
            if (!ImageEnable) begin
               mcux_d  = '0;
               mcuy_d  = '0;
               rcnt_d  = '0;
               blk_d   = '0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Losing ImageEnable mid-scan abandons the image. Completion is not
      // reported.
      if (!ImageEnable && (state_q != S_IDLE) && (state_q != S_DONE)) begin
         state_d = S_IDLE;
         mcux_d  = '0;
         mcuy_d  = '0;
         rcnt_d  = '0;
         blk_d   = '0;
         dcclr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         color_q <= 1'b0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
         cols_q  <= '0;
         rows_q  <= '0;
         rsti_q  <= '0;
         mcux_q  <= '0;
         mcuy_q  <= '0;
         rcnt_q  <= '0;
         blk_q   <= '0;
         dcclr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         hs2_q   <= hs2_d;
         vs2_q   <= vs2_d;
         cols_q  <= cols_d;
         rows_q  <= rows_d;
         rsti_q  <= rsti_d;
         mcux_q  <= mcux_d;
         mcuy_q  <= mcuy_d;
         rcnt_q  <= rcnt_d;
         blk_q   <= blk_d;
         dcclr_q <= dcclr_d;
      end
   end

   // Command fields are forced to zero outside ISSUE. This keeps every
   // output at zero while idle. Inside ISSUE they come from registered
   // state only, so they stay stable while waiting for BlockReady.
   assign BlockValid = (state_q == S_ISSUE);
   assign BlockComp  = BlockValid ? blk_comp : 2'd0;
   assign BlockPos   = BlockValid ? blk_pos  : 2'd0;
   assign BlockTable = BlockValid && (blk_comp != 2'd0);
   assign McuX       = mcux_q;
   assign McuY       = mcuy_q;
   assign RstReq     = (state_q == S_RSTW);
   assign DcClear    = dcclr_q;
   assign ImageDone  = (state_q == S_DONE);
   assign Busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aq_djpeg_mcu_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aq_djpeg_mcu_sched
//  Purpose  : Self-checking bench for aq_djpeg_mcu_sched. Builds the expected
//             command list per image from the ordering rules and compares
//             every issued command and handshake against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aq_djpeg_mcu_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ImageEnable = 1'b0;
   logic [2:0]  JpegComp = 3'd0;
   logic [1:0]  SubSamplingW = 2'd0;
   logic [1:0]  SubSamplingH = 2'd0;
   logic [11:0] McuCols = 12'd0;
   logic [11:0] McuRows = 12'd0;
   logic [15:0] RstInterval = 16'd0;
   logic        BlockValid;
   logic        BlockReady = 1'b0;
   logic [1:0]  BlockComp;
   logic [1:0]  BlockPos;
   logic        BlockTable;
   logic        BlockDone = 1'b0;
   logic [11:0] McuX;
   logic [11:0] McuY;
   logic        RstReq;
   logic        RstAck = 1'b0;
   logic        DcClear;
   logic        ImageDone;
   logic        Busy;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  comp;
      logic [1:0]  pos;
      logic        tab;
      logic [11:0] x;
      logic [11:0] y;
      bit          rst_after;
   } cmd_t;

   aq_djpeg_mcu_sched #(.BLK_W(12), .RST_W(16)) dut (
      .clk(clk), .rst(rst), .ImageEnable(ImageEnable), .JpegComp(JpegComp),
      .SubSamplingW(SubSamplingW), .SubSamplingH(SubSamplingH),
      .McuCols(McuCols), .McuRows(McuRows), .RstInterval(RstInterval),
      .BlockValid(BlockValid), .BlockReady(BlockReady), .BlockComp(BlockComp),
      .BlockPos(BlockPos), .BlockTable(BlockTable), .BlockDone(BlockDone),
      .McuX(McuX), .McuY(McuY), .RstReq(RstReq), .RstAck(RstAck),
      .DcClear(DcClear), .ImageDone(ImageDone), .Busy(Busy)
   );

   always #5 clk = ~clk;

   // Decode one image and check it against the command list built from the
   // ordering rules.
   task automatic run_image(input logic [2:0] comp, input logic [1:0] sw, input logic [1:0] sh,
                            input int cols, input int rows, input int rsti,
                            input int rmin, input int rmax, input int dmin, input int dmax,
                            input int amin, input int amax);
      cmd_t q[$];
      cmd_t c;
      cmd_t cur;
      int   hs, vs, total, mi, nrst_exp, nrst_seen, rdly, dcnt, adly;
      bit   color, have_cur, inflight, in_rst, last_rst, expect_dc, prev_dc, finished;
      hs = (sw == 2'd2) ? 2 : 1;
      vs = (sh == 2'd2) ? 2 : 1;
      color = (comp == 3'd3);
      total = cols * rows;
      nrst_exp = 0;
      for (int y = 0; y < rows; y++) begin
         for (int x = 0; x < cols; x++) begin
            mi = y * cols + x;
            c.x = 12'(x); c.y = 12'(y); c.rst_after = 1'b0;
            if (!color) begin
               c.comp = 2'd0; c.pos = 2'd0; c.tab = 1'b0; q.push_back(c);
            end else begin
               for (int v = 0; v < vs; v++)
                  for (int h = 0; h < hs; h++) begin
                     c.comp = 2'd0; c.pos = 2'(v * 2 + h); c.tab = 1'b0; q.push_back(c);
                  end
               c.comp = 2'd1; c.pos = 2'd0; c.tab = 1'b1; q.push_back(c);
               c.comp = 2'd2; q.push_back(c);
            end
            if (rsti != 0 && mi != total - 1 && ((mi + 1) % rsti) == 0) begin
               q[q.size() - 1].rst_after = 1'b1;
               nrst_exp++;
            end
         end
      end

      @(negedge clk);
      JpegComp = comp; SubSamplingW = sw; SubSamplingH = sh;
      McuCols = 12'(cols); McuRows = 12'(rows); RstInterval = 16'(rsti);
      BlockReady = 1'b0; BlockDone = 1'b0; RstAck = 1'b0;
      ImageEnable = 1'b1;
      @(negedge clk);
      checks++;
      if (BlockValid !== 1'b1) begin
         failures++; $display("FAIL first_valid: got %0d expected 1", BlockValid);
      end

      nrst_seen = 0; rdly = 0; dcnt = 0; adly = 0;
      have_cur = 0; inflight = 0; in_rst = 0; last_rst = 0; expect_dc = 0; finished = 0;
      for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
         if (cyc > 0) @(negedge clk);
         BlockReady = 1'b0; BlockDone = 1'b0; RstAck = 1'b0;
         prev_dc = expect_dc;
         expect_dc = 0;
         checks++;
         if (DcClear !== prev_dc) begin
            failures++; $display("FAIL dc_clear: got %0d expected %0d", DcClear, prev_dc);
         end
         if (prev_dc) begin
            checks++;
            if (RstReq !== 1'b0) begin
               failures++; $display("FAIL rstreq_drop: got %0d expected 0", RstReq);
            end
         end
         if (ImageDone === 1'b1) begin
            finished = 1;
         end else begin
            if (BlockValid === 1'b1 && (inflight || RstReq === 1'b1)) begin
               failures++; $display("FAIL valid_excl: got 1 expected 0");
            end
            if (BlockValid === 1'b1) begin
               if (!have_cur) begin
                  if (q.size() == 0) begin
                     failures++; $display("FAIL extra_cmd: got %0d expected 0", 1);
                     finished = 1;
                  end else begin
                     cur = q.pop_front();
                     have_cur = 1;
                     rdly = $urandom_range(rmax, rmin);
                     checks++;
                     if ({BlockComp, BlockPos, BlockTable} !== {cur.comp, cur.pos, cur.tab}) begin
                        failures++;
                        $display("FAIL cmd_fields: got comp=%0d pos=%0d tab=%0d expected comp=%0d pos=%0d tab=%0d",
                                 BlockComp, BlockPos, BlockTable, cur.comp, cur.pos, cur.tab);
                     end
                     checks++;
                     if (McuX !== cur.x || McuY !== cur.y) begin
                        failures++;
                        $display("FAIL mcu_pos: got x=%0d y=%0d expected x=%0d y=%0d", McuX, McuY, cur.x, cur.y);
                     end
                  end
               end else begin
                  checks++;
                  if ({BlockComp, BlockPos, BlockTable, McuX, McuY} !== {cur.comp, cur.pos, cur.tab, cur.x, cur.y}) begin
                     failures++;
                     $display("FAIL cmd_stable: got comp=%0d pos=%0d tab=%0d expected comp=%0d pos=%0d tab=%0d",
                              BlockComp, BlockPos, BlockTable, cur.comp, cur.pos, cur.tab);
                  end
               end
               if (have_cur) begin
                  if (rdly == 0) begin
                     BlockReady = 1'b1;
                     have_cur = 0;
                     inflight = 1;
                     last_rst = cur.rst_after;
                     dcnt = $urandom_range(dmax, dmin);
                  end else begin
                     rdly--;
                  end
               end
            end else if (have_cur) begin
               failures++; $display("FAIL valid_dropped: got 0 expected 1");
               have_cur = 0;
            end else if (inflight) begin
               dcnt--;
               if (dcnt <= 0) begin
                  BlockDone = 1'b1;
                  inflight = 0;
               end
            end
            if (RstReq === 1'b1) begin
               if (!in_rst) begin
                  in_rst = 1;
                  nrst_seen++;
                  adly = $urandom_range(amax, amin);
                  checks++;
                  if (!last_rst) begin
                     failures++; $display("FAIL rst_position: got restart expected none (block %0d)", nrst_seen);
                  end
               end
               if (adly == 0) begin
                  RstAck = 1'b1;
                  expect_dc = 1;
                  in_rst = 0;
               end else begin
                  adly--;
               end
            end
         end
      end

      checks++;
      if (!finished) begin
         failures++; $display("FAIL image_timeout: got 0 expected ImageDone=1");
      end
      checks++;
      if (q.size() != 0 || have_cur) begin
         failures++; $display("FAIL cmds_left: got %0d expected 0", q.size());
      end
      checks++;
      if (nrst_seen != nrst_exp) begin
         failures++; $display("FAIL rst_count: got %0d expected %0d", nrst_seen, nrst_exp);
      end
      checks++;
      if (Busy !== 1'b1) begin
         failures++; $display("FAIL busy_done: got %0d expected 1", Busy);
      end
      ImageEnable = 1'b0;
      @(negedge clk);
      checks++;
      if (ImageDone !== 1'b0 || Busy !== 1'b0) begin
         failures++; $display("FAIL idle_after: got done=%0d busy=%0d expected 0 0", ImageDone, Busy);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({BlockValid, BlockComp, BlockPos, BlockTable, McuX, McuY, RstReq, DcClear, ImageDone, Busy} !== '0) begin
         failures++; $display("FAIL reset_outputs: got nonzero expected 0");
      end
   endtask

   task automatic test_gray();
      run_image(3'd1, 2'd0, 2'd0, 2, 1, 0, 0, 0, 3, 3, 0, 0);
   endtask

   task automatic test_color_2x2();
      run_image(3'd3, 2'd2, 2'd2, 1, 1, 0, 0, 0, 1, 3, 0, 0);
   endtask

   task automatic test_color_2x1_1x2();
      run_image(3'd3, 2'd2, 2'd1, 1, 1, 0, 0, 1, 1, 2, 0, 0);
      run_image(3'd3, 2'd1, 2'd2, 1, 1, 0, 0, 1, 1, 2, 0, 0);
   endtask

   task automatic test_restart();
      run_image(3'd0, 2'd0, 2'd0, 3, 1, 1, 0, 0, 1, 2, 4, 4);
   endtask

   task automatic test_ready_stall();
      run_image(3'd3, 2'd1, 2'd1, 1, 1, 0, 5, 5, 2, 2, 0, 0);
   endtask

   task automatic test_zero_rows();
      @(negedge clk);
      JpegComp = 3'd3; McuCols = 12'd5; McuRows = 12'd0; RstInterval = 16'd0;
      ImageEnable = 1'b1;
      @(negedge clk);
      checks++;
      if (ImageDone !== 1'b1 || BlockValid !== 1'b0 || Busy !== 1'b1) begin
         failures++; $display("FAIL zero_rows_done: got done=%0d valid=%0d expected 1 0", ImageDone, BlockValid);
      end
      @(negedge clk);
      checks++;
      if (ImageDone !== 1'b1) begin
         failures++; $display("FAIL zero_rows_hold: got %0d expected 1", ImageDone);
      end
      ImageEnable = 1'b0;
      @(negedge clk);
      checks++;
      if (ImageDone !== 1'b0 || Busy !== 1'b0) begin
         failures++; $display("FAIL zero_rows_idle: got done=%0d busy=%0d expected 0 0", ImageDone, Busy);
      end
   endtask

   task automatic test_abort();
      bit seen_done;
      @(negedge clk);
      JpegComp = 3'd0; SubSamplingW = 2'd0; SubSamplingH = 2'd0;
      McuCols = 12'd2; McuRows = 12'd1; RstInterval = 16'd0;
      ImageEnable = 1'b1;
      @(negedge clk);
      BlockReady = 1'b1;
      @(negedge clk);
      BlockReady = 1'b0;
      BlockDone = 1'b1;
      @(negedge clk);
      BlockDone = 1'b0;
      @(negedge clk);
      checks++;
      if (BlockValid !== 1'b1 || McuX !== 12'd1) begin
         failures++; $display("FAIL abort_setup: got valid=%0d x=%0d expected 1 1", BlockValid, McuX);
      end
      BlockReady = 1'b1;
      @(negedge clk);
      BlockReady = 1'b0;
      checks++;
      if (Busy !== 1'b1 || BlockValid !== 1'b0) begin
         failures++; $display("FAIL abort_wait: got busy=%0d valid=%0d expected 1 0", Busy, BlockValid);
      end
      ImageEnable = 1'b0;
      @(negedge clk);
      checks++;
      if ({BlockValid, BlockComp, BlockPos, BlockTable, McuX, McuY, RstReq, DcClear, ImageDone, Busy} !== '0) begin
         failures++; $display("FAIL abort_idle: got busy=%0d x=%0d expected all 0", Busy, McuX);
      end
      seen_done = 0;
      BlockDone = 1'b1;
      repeat (4) begin
         @(negedge clk);
         BlockDone = 1'b0;
         if (ImageDone === 1'b1) seen_done = 1;
      end
      checks++;
      if (seen_done || Busy !== 1'b0) begin
         failures++; $display("FAIL abort_no_done: got done=%0d busy=%0d expected 0 0", seen_done, Busy);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      JpegComp = 3'd3; SubSamplingW = 2'd2; SubSamplingH = 2'd2;
      McuCols = 12'd2; McuRows = 12'd2; RstInterval = 16'd1;
      ImageEnable = 1'b1;
      @(negedge clk);
      checks++;
      if (Busy !== 1'b1) begin
         failures++; $display("FAIL async_setup: got %0d expected 1", Busy);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({BlockValid, BlockComp, BlockPos, BlockTable, McuX, McuY, RstReq, DcClear, ImageDone, Busy} !== '0) begin
         failures++; $display("FAIL async_reset: got busy=%0d valid=%0d expected 0 0", Busy, BlockValid);
      end
      @(negedge clk);
      ImageEnable = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0) begin
         failures++; $display("FAIL async_release: got %0d expected 0", Busy);
      end
   endtask

   task automatic test_random();
      logic [2:0] comp;
      for (int n = 0; n < 8; n++) begin
         comp = 3'($urandom_range(7, 0));
         if ($urandom_range(1, 0) == 1) comp = 3'd3;
         run_image(comp, 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                   $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(4, 0),
                   0, 3, 1, 4, 0, 3);
      end
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      @(negedge clk);
      test_gray();
      test_color_2x2();
      test_color_2x1_1x2();
      test_restart();
      test_ready_stall();
      test_zero_rows();
      test_abort();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
